aibcr3_rxdeser: RTL and testbench

Parametrised multi-channel RX deserialiser for the AIB receive path. It takes per-channel DDR bit pairs that are already retimed into the distributed core clock (even/odd samples of the strobe) and assembles them into wide parallel words. RX mode decode uses the 3-bit `irxen` encoding, adding SDR packing, async bypass and beat-level bit-slip alignment. It sits between the per-pad RX capture cells and the adapter core interface.

---
 rtl/aibcr3_rxdeser.sv | 125 ++++++++++++
 tb/tb_aibcr3_rxdeser.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aibcr3_rxdeser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aibcr3_rxdeser : multi-channel AIB RX deserialiser (DDR/SDR/bypass/slip)  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module aibcr3_rxdeser #(
  parameter int NCH   = 4,
  parameter int RATIO = 4
) (
  input  logic                    iclkin_dist,
  input  logic                    irst,
  input  logic [2:0]              irxen,
  input  logic [NCH-1:0]          idat0,
  input  logic [NCH-1:0]          idat1,
  input  logic                    ibitslip,
  output logic [NCH*2*RATIO-1:0]  odata,
  output logic                    ovalid,
  output logic                    orx_disable,
  output logic                    osdr_mode
);

  localparam int W  = 2 * RATIO;
  localparam int CW = $clog2(2 * RATIO);
  localparam logic [CW-1:0] DDR_LAST = CW'(RATIO - 1);
  localparam logic [CW-1:0] SDR_LAST = CW'(2 * RATIO - 1);
  localparam logic [2:0]    RXEN_DISABLE = 3'b010;

  typedef enum logic [1:0] {
    MODE_DIS = 2'd0,
    MODE_DDR = 2'd1,
    MODE_SDR = 2'd2,
    MODE_BYP = 2'd3
  } mode_e;

  logic [2:0]       mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NCH*W-1:0] sr_q, sr_d;
  logic [NCH*W-1:0] odata_q, odata_d;
  logic             ovalid_q, ovalid_d;
  logic [NCH*W-1:0] sr_shift;
  logic [NCH*W-1:0] byp_word;
  logic [CW-1:0]    cnt_last;
  mode_e            mode_cur;

  always_comb begin
    case (mode_q)
      3'b001:  mode_cur = MODE_DDR;
      3'b100:  mode_cur = MODE_SDR;
      3'b000:  mode_cur = MODE_BYP;
      default: mode_cur = MODE_DIS;
    endcase
  end

  // Newest beat enters at the top so the first-arriving bit ends up at bit 0.
  for (genvar c = 0; c < NCH; c++) begin : g_chan
    assign sr_shift[c*W +: W] = (mode_cur == MODE_SDR)
                              ? {idat0[c], sr_q[c*W+1 +: W-1]}
                              : {idat1[c], idat0[c], sr_q[c*W+2 +: W-2]};
    assign byp_word[c*W +: W] = {{(W-1){1'b0}}, idat0[c]};
  end

  always_comb begin
    mode_d   = irxen;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    odata_d  = odata_q;
    ovalid_d = 1'b0;
    cnt_last = (mode_cur == MODE_SDR) ? SDR_LAST : DDR_LAST;
    if (irxen != mode_q) begin
      // Mode-change edge: restart framing, keep the last word on the bus.
      cnt_d = '0;
      sr_d  = '0;
    end else begin
      case (mode_cur)
        MODE_DDR, MODE_SDR: begin
          sr_d = sr_shift;
          // A slip keeps shifting but freezes the count, pushing the boundary one beat later.
          if (!ibitslip) begin
            if (cnt_q == cnt_last) begin
              odata_d  = sr_shift;
              ovalid_d = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        MODE_BYP: begin
          odata_d  = byp_word;
          ovalid_d = 1'b1;
          cnt_d    = '0;
          sr_d     = '0;
        end
        default: begin
          odata_d = '0;
          cnt_d   = '0;
          sr_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge iclkin_dist or posedge irst) begin
    if (irst) begin
      mode_q   <= RXEN_DISABLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign odata       = odata_q;
  assign ovalid      = ovalid_q;
  assign orx_disable = (mode_cur == MODE_DIS);
  assign osdr_mode   = (mode_cur == MODE_SDR);

endmodule
`default_nettype wire

// File: tb/tb_aibcr3_rxdeser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_aibcr3_rxdeser : scoreboard bench for aibcr3_rxdeser                   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_aibcr3_rxdeser;

  typedef struct {
    int             id;
    logic [511:0]   d;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic clk;
  logic rst;

  // instance A: NCH=4, RATIO=4
  logic [2:0]  rxen_a;
  logic [3:0]  d0a, d1a;
  logic        slip_a;
  logic [31:0] oda;
  logic        ova, dis_a, sdr_a;

  // instance B: NCH=1, RATIO=2
  logic [2:0]  rxen_b;
  logic [0:0]  d0b, d1b;
  logic        slip_b;
  logic [3:0]  odb;
  logic        ovb, dis_b, sdr_b;

  // instance C: NCH=32, RATIO=8
  logic [2:0]   rxen_c;
  logic [31:0]  d0c, d1c;
  logic         slip_c;
  logic [511:0] odc;
  logic         ovc, dis_c, sdr_c;

  aibcr3_rxdeser #(.NCH(4), .RATIO(4)) u_dut_a (
    .iclkin_dist(clk), .irst(rst), .irxen(rxen_a), .idat0(d0a), .idat1(d1a),
    .ibitslip(slip_a), .odata(oda), .ovalid(ova), .orx_disable(dis_a), .osdr_mode(sdr_a));

  aibcr3_rxdeser #(.NCH(1), .RATIO(2)) u_dut_b (
    .iclkin_dist(clk), .irst(rst), .irxen(rxen_b), .idat0(d0b), .idat1(d1b),
    .ibitslip(slip_b), .odata(odb), .ovalid(ovb), .orx_disable(dis_b), .osdr_mode(sdr_b));

  aibcr3_rxdeser #(.NCH(32), .RATIO(8)) u_dut_c (
    .iclkin_dist(clk), .irst(rst), .irxen(rxen_c), .idat0(d0c), .idat1(d1c),
    .ibitslip(slip_c), .odata(odc), .ovalid(ovc), .orx_disable(dis_c), .osdr_mode(sdr_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic mon(input int id, input logic v, input logic [511:0] d);
    exp_t e;
    if (v !== 1'b0) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ovalid: dut %0d got ovalid=%b want 0 (cycle %0d)", id, v, cyc);
      end else begin
        e = sb.pop_front();
        chk("word_src", 512'(id), 512'(e.id));
        chk("word_cycle", 512'(cyc), 512'(e.cyc));
        chk("word_data", d, e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ova, {480'b0, oda});
    mon(1, ovb, {508'b0, odb});
    mon(2, ovc, odc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected word appears after the next rising edge
  task automatic push(input int id, input logic [511:0] d);
    exp_t e;
    e.id  = id;
    e.d   = d;
    e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic beat_a(input logic [31:0] w, input int k, input bit slip, input bit sdr);
    for (int c = 0; c < 4; c++) begin
      if (sdr) begin
        d0a[c] = w[c*8 + k];
        d1a[c] = 1'($urandom);
      end else begin
        d0a[c] = w[c*8 + 2*k];
        d1a[c] = w[c*8 + 2*k + 1];
      end
    end
    slip_a = slip;
    tick();
    slip_a = 1'b0;
  endtask

  task automatic word_a(input logic [31:0] w, input bit sdr);
    int n;
    n = sdr ? 8 : 4;
    for (int k = 0; k < n - 1; k++) beat_a(w, k, 1'b0, sdr);
    push(0, {480'b0, w});
    beat_a(w, n - 1, 1'b0, sdr);
  endtask

  task automatic beat_b(input logic [3:0] w, input int k, input bit sdr);
    if (sdr) begin
      d0b[0] = w[k];
      d1b[0] = 1'($urandom);
    end else begin
      d0b[0] = w[2*k];
      d1b[0] = w[2*k + 1];
    end
    tick();
  endtask

  task automatic beat_c(input logic [511:0] w, input int k, input bit sdr);
    for (int c = 0; c < 32; c++) begin
      if (sdr) begin
        d0c[c] = w[c*16 + k];
        d1c[c] = 1'($urandom);
      end else begin
        d0c[c] = w[c*16 + 2*k];
        d1c[c] = w[c*16 + 2*k + 1];
      end
    end
    tick();
  endtask

  // mode-change edge: data and slip presented here must be discarded
  task automatic mode_set(input int id, input logic [2:0] m);
    if (id == 0) rxen_a = m;
    else if (id == 1) rxen_b = m;
    else rxen_c = m;
    d0a = 4'($urandom); d1a = 4'($urandom); slip_a = 1'b1;
    d0b = 1'($urandom); d1b = 1'($urandom);
    d0c = $urandom;     d1c = $urandom;
    tick();
    slip_a = 1'b0;
  endtask

  localparam logic [31:0] P    = 32'hFF00_A54E;  // ch0 beats (0,1),(1,1),(0,0),(1,0)
  localparam logic [31:0] R1   = 32'hFF00_6993;  // boundary one beat later
  localparam logic [31:0] R2   = 32'hFF00_5AE4;  // boundary two beats later
  localparam logic [31:0] S    = 32'h8001_3C8D;  // ch0 SDR bits 1,0,1,1,0,0,0,1
  localparam logic [31:0] SR   = 32'h4080_1EC6;  // SDR boundary one bit later

  initial begin
    logic [3:0]   bv;
    logic [31:0]  be;
    logic [3:0]   wb;
    logic [511:0] wc;
    logic [3:0]   byp_vals [6];

    rst = 1'b1;
    rxen_a = 3'b010; rxen_b = 3'b010; rxen_c = 3'b010;
    d0a = '0; d1a = '0; slip_a = 1'b0;
    d0b = '0; d1b = '0; slip_b = 1'b0;
    d0c = '0; d1c = '0; slip_c = 1'b0;
    byp_vals = '{4'b0001, 4'b1010, 4'b1111, 4'b0000, 4'b0110, 4'b1001};

    #12;
    chk("reset_odata", {480'b0, oda}, '0);
    chk("reset_ovalid", 512'(ova), 512'(0));
    chk("reset_rx_disable", 512'(dis_a), 512'(1));
    chk("reset_sdr_mode", 512'(sdr_a), 512'(0));
    tick();
    rst = 1'b0;

    // DDR, continuous words
    mode_set(0, 3'b001);
    chk("ddr_rx_disable", 512'(dis_a), 512'(0));
    chk("ddr_sdr_mode", 512'(sdr_a), 512'(0));
    word_a(P, 1'b0);
    word_a(P, 1'b0);
    word_a(32'h1234_5678, 1'b0);
    word_a(P, 1'b0);

    // single slip at count 0: one 5-cycle period, then rotated words
    beat_a(P, 0, 1'b1, 1'b0);
    for (int k = 1; k < 4; k++) beat_a(P, k, 1'b0, 1'b0);
    push(0, {480'b0, R1});
    beat_a(P, 0, 1'b0, 1'b0);
    repeat (2) begin
      for (int k = 1; k < 4; k++) beat_a(P, k, 1'b0, 1'b0);
      push(0, {480'b0, R1});
      beat_a(P, 0, 1'b0, 1'b0);
    end

    // slip on terminal count delays the word by one edge
    for (int k = 1; k < 4; k++) beat_a(P, k, 1'b0, 1'b0);
    beat_a(P, 0, 1'b1, 1'b0);
    push(0, {480'b0, R2});
    beat_a(P, 1, 1'b0, 1'b0);

    // back-to-back slips realign to the original pattern
    beat_a(P, 2, 1'b1, 1'b0);
    beat_a(P, 3, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) beat_a(P, k, 1'b0, 1'b0);
    push(0, {480'b0, P});
    beat_a(P, 3, 1'b0, 1'b0);

    // partial word then bypass
    beat_a(P, 0, 1'b0, 1'b0);
    beat_a(P, 1, 1'b0, 1'b0);
    mode_set(0, 3'b000);
    for (int i = 0; i < 6; i++) begin
      bv = byp_vals[i];
      be = '0;
      for (int c = 0; c < 4; c++) be[c*8] = bv[c];
      push(0, {480'b0, be});
      d0a = bv;
      d1a = ~bv;
      slip_a = (i == 2);
      tick();
      slip_a = 1'b0;
    end

    // illegal code behaves as disable
    mode_set(0, 3'b111);
    tick();
    tick();
    chk("dis_odata", {480'b0, oda}, '0);
    chk("dis_ovalid", 512'(ova), 512'(0));
    chk("dis_rx_disable", 512'(dis_a), 512'(1));
    chk("dis_sdr_mode", 512'(sdr_a), 512'(0));

    // SDR
    mode_set(0, 3'b100);
    chk("sdr_sdr_mode", 512'(sdr_a), 512'(1));
    chk("sdr_rx_disable", 512'(dis_a), 512'(0));
    word_a(S, 1'b1);
    word_a(S, 1'b1);
    beat_a(S, 0, 1'b1, 1'b1);
    for (int k = 1; k < 8; k++) beat_a(S, k, 1'b0, 1'b1);
    push(0, {480'b0, SR});
    beat_a(S, 0, 1'b0, 1'b1);

    // async reset mid-word
    mode_set(0, 3'b001);
    beat_a(P, 0, 1'b0, 1'b0);
    beat_a(P, 1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_odata", {480'b0, oda}, '0);
    chk("arst_ovalid", 512'(ova), 512'(0));
    chk("arst_rx_disable", 512'(dis_a), 512'(1));
    tick();
    rst = 1'b0;
    mode_set(0, 3'b001);
    word_a(P, 1'b0);
    mode_set(0, 3'b010);

    // sweep NCH=1 RATIO=2
    mode_set(1, 3'b001);
    for (int i = 0; i < 8; i++) begin
      wb = 4'($urandom);
      beat_b(wb, 0, 1'b0);
      push(1, {508'b0, wb});
      beat_b(wb, 1, 1'b0);
    end
    mode_set(1, 3'b100);
    for (int i = 0; i < 3; i++) begin
      wb = 4'($urandom);
      for (int k = 0; k < 3; k++) beat_b(wb, k, 1'b1);
      push(1, {508'b0, wb});
      beat_b(wb, 3, 1'b1);
    end
    mode_set(1, 3'b010);

    // sweep NCH=32 RATIO=8
    mode_set(2, 3'b001);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 16; j++) wc[j*32 +: 32] = $urandom;
      for (int k = 0; k < 7; k++) beat_c(wc, k, 1'b0);
      push(2, wc);
      beat_c(wc, 7, 1'b0);
    end
    mode_set(2, 3'b100);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 16; j++) wc[j*32 +: 32] = $urandom;
      for (int k = 0; k < 15; k++) beat_c(wc, k, 1'b1);
      push(2, wc);
      beat_c(wc, 15, 1'b1);
    end
    mode_set(2, 3'b010);

    repeat (3) tick();
    chk("sb_drain", 512'(sb.size()), 512'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
